// File: rtl/connectivity_audit.sv
// Netlist connectivity checker: counts drivers and connections per net from a pin stream,
// then scans the table and reports undriven, under-connected and multiply-driven nets.
module connectivity_audit #(
  parameter int unsigned NET_W = 6,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             restart,
  input  logic             pin_valid,
  output logic             pin_ready,
  input  logic [NET_W-1:0] pin_net,
  input  logic             pin_is_drv,
  input  logic             pin_last,
  output logic             viol_valid,
  input  logic             viol_ready,
  output logic [NET_W-1:0] viol_net,
  output logic [1:0]       viol_code,
  output logic             done,
  output logic [NET_W+1:0] n_viol
);

  localparam int unsigned Depth = 2 ** NET_W;
  localparam logic [NET_W-1:0] IdxLast = '1;
  localparam logic [CNT_W-1:0] CntMax = '1;

  typedef enum logic [1:0] {StClear, StCollect, StScan, StDone} state_e;

  state_e           r_state, w_state_nxt;
  logic [NET_W-1:0] r_idx, w_idx_nxt;
  logic             r_sub, w_sub_nxt;
  logic [NET_W+1:0] r_nviol, w_nviol_nxt;

  logic [1:0]       r_drv  [Depth];
  logic [CNT_W-1:0] r_conn [Depth];

  logic             w_pin_acc;
  logic [1:0]       w_cur_drv, w_drv_inc;
  logic [CNT_W-1:0] w_cur_conn, w_conn_inc;
  logic [1:0]       w_scan_drv;
  logic [CNT_W-1:0] w_scan_conn;
  logic             w_ref, w_low_conn, w_need0, w_need1, w_need2, w_pend;
  logic [1:0]       w_code;

  assign w_pin_acc  = (r_state == StCollect) && pin_valid;
  assign w_cur_drv  = r_drv[pin_net];
  assign w_cur_conn = r_conn[pin_net];
  assign w_drv_inc  = (pin_is_drv && (w_cur_drv != 2'd2)) ? w_cur_drv + 2'd1 : w_cur_drv;
  assign w_conn_inc = (w_cur_conn != CntMax) ? w_cur_conn + CNT_W'(1) : w_cur_conn;

  // r_sub marks that code 0 was already sent for the current net
  assign w_scan_drv  = r_drv[r_idx];
  assign w_scan_conn = r_conn[r_idx];
  assign w_ref       = (w_scan_conn != '0);
  assign w_low_conn  = (w_scan_conn < CNT_W'(2));
  assign w_need0     = w_ref && (w_scan_drv == 2'd0) && !r_sub;
  assign w_need1     = w_ref && w_low_conn && !w_need0;
  assign w_need2     = w_ref && (w_scan_drv >= 2'd2);
  assign w_pend      = w_need0 || w_need1 || w_need2;
  assign w_code      = w_need0 ? 2'd0 : (w_need1 ? 2'd1 : 2'd2);

  always_ff @(posedge clk) begin
    if (r_state == StClear) begin
      r_drv[r_idx]  <= '0;
      r_conn[r_idx] <= '0;
    end else if (w_pin_acc) begin
      r_drv[pin_net]  <= w_drv_inc;
      r_conn[pin_net] <= w_conn_inc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StClear;
      r_idx   <= '0;
      r_sub   <= 1'b0;
      r_nviol <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_sub   <= w_sub_nxt;
      r_nviol <= w_nviol_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_sub_nxt   = r_sub;
    w_nviol_nxt = r_nviol;
    unique case (r_state)
      StClear: begin
        w_idx_nxt = r_idx + NET_W'(1);
        if (r_idx == IdxLast) w_state_nxt = StCollect;
      end
      StCollect: begin
        if (w_pin_acc && pin_last) begin
          w_state_nxt = StScan;
          w_idx_nxt   = '0;
          w_sub_nxt   = 1'b0;
        end
      end
      StScan: begin
        if (w_pend && viol_ready) w_nviol_nxt = r_nviol + (NET_W + 2)'(1);
        if (!w_pend || viol_ready) begin
          if (w_need0 && w_low_conn) begin
            w_sub_nxt = 1'b1;
          end else begin
            w_sub_nxt = 1'b0;
            w_idx_nxt = r_idx + NET_W'(1);
            if (r_idx == IdxLast) w_state_nxt = StDone;
          end
        end
      end
      StDone: begin
        if (restart) begin
          w_state_nxt = StClear;
          w_idx_nxt   = '0;
          w_nviol_nxt = '0;
        end
      end
      default: w_state_nxt = StClear;
    endcase
  end

  assign pin_ready  = (r_state == StCollect);
  assign viol_valid = (r_state == StScan) && w_pend;
  assign viol_net   = viol_valid ? r_idx : '0;
  assign viol_code  = viol_valid ? w_code : 2'd0;
  assign done       = (r_state == StDone);
  assign n_viol     = r_nviol;

endmodule

// File: tb/tb_connectivity_audit.sv
// Directed bench for connectivity_audit: hand-computed violation lists per scenario.
module tb_connectivity_audit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       restart = 1'b0;
  logic       pin_valid = 1'b0;
  logic       pin_ready;
  logic [5:0] pin_net = '0;
  logic       pin_is_drv = 1'b0;
  logic       pin_last = 1'b0;
  logic       viol_valid;
  logic       viol_ready = 1'b0;
  logic [5:0] viol_net;
  logic [1:0] viol_code;
  logic       done;
  logic [7:0] n_viol;

  int n_vec = 0;
  int n_err = 0;
  int got_n;
  int got_net [8];
  int got_code [8];

  connectivity_audit #(.NET_W(6), .CNT_W(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .restart    (restart),
    .pin_valid  (pin_valid),
    .pin_ready  (pin_ready),
    .pin_net    (pin_net),
    .pin_is_drv (pin_is_drv),
    .pin_last   (pin_last),
    .viol_valid (viol_valid),
    .viol_ready (viol_ready),
    .viol_net   (viol_net),
    .viol_code  (viol_code),
    .done       (done),
    .n_viol     (n_viol)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; counts cycles until pin_ready rises.
  task automatic wait_clear(input string tag);
    int cnt = 0;
    while (!pin_ready && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    chk(tag, cnt, 64);
  endtask

  task automatic send_pin(input int net, input bit drv, input bit last);
    int t = 0;
    pin_valid  = 1'b1;
    pin_net    = 6'(net);
    pin_is_drv = drv;
    pin_last   = last;
    while (!pin_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) chk("pin_timeout", 1, 0);
    @(negedge clk);
    pin_valid = 1'b0;
    pin_last  = 1'b0;
  endtask

  task automatic run_scan(input int hold);
    int t = 0;
    logic [5:0] n0;
    logic [1:0] c0;
    got_n = 0;
    viol_ready = (hold == 0);
    while (!done && t < 3000) begin
      if (viol_valid) begin
        n0 = viol_net;
        c0 = viol_code;
        if (hold > 0) begin
          for (int w = 0; w < hold; w++) @(negedge clk);
          chk("hold_valid", viol_valid, 1);
          chk("hold_net", viol_net, n0);
          chk("hold_code", viol_code, c0);
          viol_ready = 1'b1;
          @(negedge clk);
          viol_ready = 1'b0;
        end else begin
          @(negedge clk);
        end
        if (got_n < 8) begin
          got_net[got_n]  = n0;
          got_code[got_n] = c0;
        end
        got_n++;
      end else begin
        @(negedge clk);
      end
      t++;
    end
    chk("scan_done", done, 1);
  endtask

  task automatic basic_pins();
    send_pin(2, 1, 0); send_pin(2, 0, 0);
    send_pin(3, 1, 0); send_pin(3, 0, 0);
    send_pin(5, 1, 0);
    send_pin(7, 0, 1);
  endtask

  task automatic check_basic(input string tag);
    chk({tag, "_count"}, got_n, 3);
    chk({tag, "_net0"}, got_net[0], 5);  chk({tag, "_code0"}, got_code[0], 1);
    chk({tag, "_net1"}, got_net[1], 7);  chk({tag, "_code1"}, got_code[1], 0);
    chk({tag, "_net2"}, got_net[2], 7);  chk({tag, "_code2"}, got_code[2], 1);
    chk({tag, "_nviol"}, n_viol, 3);
  endtask

  task automatic do_restart(input string tag);
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    chk({tag, "_done_clr"}, done, 0);
    chk({tag, "_nviol_clr"}, n_viol, 0);
    wait_clear({tag, "_clear_len"});
  endtask

  initial begin
    int t;
    #2;
    chk("rst_pin_ready", pin_ready, 0);
    chk("rst_viol_valid", viol_valid, 0);
    chk("rst_viol_net", viol_net, 0);
    chk("rst_viol_code", viol_code, 0);
    chk("rst_done", done, 0);
    chk("rst_n_viol", n_viol, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_clear("init_clear_len");

    // Basic audit
    basic_pins();
    run_scan(0);
    check_basic("basic");

    // Multi-driver after restart
    do_restart("rs1");
    send_pin(9, 1, 0); send_pin(9, 1, 0); send_pin(9, 0, 0);
    send_pin(4, 1, 0); send_pin(4, 0, 1);
    run_scan(0);
    chk("multi_count", got_n, 1);
    chk("multi_net", got_net[0], 9);
    chk("multi_code", got_code[0], 2);
    chk("multi_nviol", n_viol, 1);

    // Saturation: 10 loads + 1 driver on net 1
    do_restart("rs2");
    for (int i = 0; i < 10; i++) send_pin(1, 0, 0);
    send_pin(1, 1, 1);
    run_scan(0);
    chk("sat_count", got_n, 0);
    chk("sat_nviol", n_viol, 0);

    // Wrap would give conn=1 on net 1 and drv=0 on net 12
    do_restart("rs3");
    for (int i = 0; i < 8; i++) send_pin(1, 0, 0);
    send_pin(1, 1, 0);
    for (int i = 0; i < 4; i++) send_pin(12, 1, i == 3);
    run_scan(0);
    chk("wrap_count", got_n, 1);
    chk("wrap_net", got_net[0], 12);
    chk("wrap_code", got_code[0], 2);
    chk("wrap_nviol", n_viol, 1);

    // Backpressure
    do_restart("rs4");
    basic_pins();
    run_scan(5);
    check_basic("bp");

    // Reset mid-scan with a record pending
    do_restart("rs5");
    basic_pins();
    viol_ready = 1'b1;
    t = 0;
    while (!viol_valid && t < 200) begin @(negedge clk); t++; end
    chk("mid_first_net", viol_net, 5);
    @(negedge clk);
    viol_ready = 1'b0;
    t = 0;
    while (!viol_valid && t < 200) begin @(negedge clk); t++; end
    chk("mid_pending_net", viol_net, 7);
    chk("mid_nviol_pre", n_viol, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_viol_valid", viol_valid, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_nviol", n_viol, 0);
    chk("mid_rst_pin_ready", pin_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_clear("mid_clear_len");
    chk("mid_pin_ready", pin_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
